// File: rtl/data_bus_hub_if.sv
// Bundle of the data_bus_hub source/destination handshake signals.
// The hub connects through the slave modport; the traffic side uses master.
interface data_bus_hub_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_PORTS  = 4,
  parameter int ID_W       = 2,
  parameter int CNT_W      = 8
);
  logic [NUM_PORTS-1:0]            src_valid;
  logic [NUM_PORTS-1:0]            src_ready;
  logic [NUM_PORTS*DATA_WIDTH-1:0] src_data;
  logic [NUM_PORTS*ID_W-1:0]       src_dst;
  logic [NUM_PORTS-1:0]            dst_valid;
  logic [NUM_PORTS*DATA_WIDTH-1:0] dst_data;
  logic [NUM_PORTS*ID_W-1:0]       dst_src;
  logic [NUM_PORTS-1:0]            dst_ready;
  logic [CNT_W-1:0]                drop_cnt;

  modport master (
    output src_valid, src_data, src_dst, dst_ready,
    input  src_ready, dst_valid, dst_data, dst_src, drop_cnt
  );

  modport slave (
    input  src_valid, src_data, src_dst, dst_ready,
    output src_ready, dst_valid, dst_data, dst_src, drop_cnt
  );
endinterface

// File: rtl/data_bus_hub.sv
// Shared data bus hub: round-robin arbitration of NUM_PORTS sources onto
// one-word registered destination slots, with a saturating drop counter.
module data_bus_hub #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_PORTS  = 4,
  parameter int ID_W       = 2,
  parameter int CNT_W      = 8
) (
  input logic           clk,
  input logic           rst_n,
  data_bus_hub_if.slave bus
);

  logic [NUM_PORTS-1:0]            dst_valid_q, dst_valid_d;
  logic [NUM_PORTS*DATA_WIDTH-1:0] dst_data_q, dst_data_d;
  logic [NUM_PORTS*ID_W-1:0]       dst_src_q, dst_src_d;
  logic [CNT_W-1:0]                drop_cnt_q, drop_cnt_d;
  logic [ID_W-1:0]                 last_grant_q, last_grant_d;

  logic [NUM_PORTS-1:0]  eligible;
  logic [NUM_PORTS-1:0]  grant_oh;
  logic                  grant_any;
  logic [ID_W-1:0]       grant_id;
  logic [DATA_WIDTH-1:0] grant_data;
  logic [31:0]           grant_dst;
  logic [31:0]           elig_dst;
  logic [31:0]           arb_dist;
  logic [31:0]           arb_best;

  // A source may go when its slot is empty, draining now, or the id is out of range.
  always_comb begin
    eligible = '0;
    elig_dst = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      elig_dst = 32'(bus.src_dst[i*ID_W +: ID_W]);
      if (bus.src_valid[i]) begin
        if (elig_dst >= 32'(NUM_PORTS)) begin
          eligible[i] = 1'b1;
        end
        for (int unsigned j = 0; j < NUM_PORTS; j++) begin
          if (elig_dst == 32'(j) && (!dst_valid_q[j] || bus.dst_ready[j])) begin
            eligible[i] = 1'b1;
          end
        end
      end
    end
  end

  // Round-robin expressed as minimum rotated distance from last_grant+1,
  // which avoids a variable-index modulo walk.
  always_comb begin
    grant_oh   = '0;
    grant_any  = 1'b0;
    grant_id   = '0;
    grant_data = '0;
    grant_dst  = '0;
    arb_dist   = '0;
    arb_best   = 32'(NUM_PORTS);
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      arb_dist = 32'(i) + 32'(NUM_PORTS) - 32'd1 - 32'(last_grant_q);
      if (arb_dist >= 32'(NUM_PORTS)) begin
        arb_dist = arb_dist - 32'(NUM_PORTS);
      end
      if (eligible[i] && arb_dist < arb_best) begin
        arb_best    = arb_dist;
        grant_any   = 1'b1;
        grant_oh    = '0;
        grant_oh[i] = 1'b1;
        grant_id    = ID_W'(i);
        grant_data  = bus.src_data[i*DATA_WIDTH +: DATA_WIDTH];
        grant_dst   = 32'(bus.src_dst[i*ID_W +: ID_W]);
      end
    end
  end

  always_comb begin
    dst_valid_d  = dst_valid_q & ~bus.dst_ready;
    dst_data_d   = dst_data_q;
    dst_src_d    = dst_src_q;
    drop_cnt_d   = drop_cnt_q;
    last_grant_d = last_grant_q;
    if (grant_any) begin
      last_grant_d = grant_id;
      if (grant_dst >= 32'(NUM_PORTS)) begin
        if (drop_cnt_q != '1) begin
          drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
      end else begin
        for (int unsigned j = 0; j < NUM_PORTS; j++) begin
          if (grant_dst == 32'(j)) begin
            dst_valid_d[j]                          = 1'b1;
            dst_data_d[j*DATA_WIDTH +: DATA_WIDTH]  = grant_data;
            dst_src_d[j*ID_W +: ID_W]               = grant_id;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dst_valid_q  <= '0;
      dst_data_q   <= '0;
      dst_src_q    <= '0;
      drop_cnt_q   <= '0;
      last_grant_q <= ID_W'(NUM_PORTS - 1);
    end else begin
      dst_valid_q  <= dst_valid_d;
      dst_data_q   <= dst_data_d;
      dst_src_q    <= dst_src_d;
      drop_cnt_q   <= drop_cnt_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.src_ready = rst_n ? grant_oh : '0;
  assign bus.dst_valid = dst_valid_q;
  assign bus.dst_data  = dst_data_q;
  assign bus.dst_src   = dst_src_q;
  assign bus.drop_cnt  = drop_cnt_q;

endmodule

// File: doc/data_bus_hub.md
Name: data_bus_hub

Overview:
- Parametrised successor to the daisy-chained data_bus segment.
- Connects NUM_PORTS module ports over one shared, arbitrated data bus with valid/ready handshakes, a registered per-destination output stage and round-robin fairness.
- Sits between controller, core, interface and future peripherals, and replaces the left/right chain.
- Carries at most one transfer per cycle; each destination holds one word until it is accepted.

Parameters:
- DATA_WIDTH, 8, width of one bus word.
- NUM_PORTS, 4, number of source/destination port pairs (2..16).
- ID_W, 2, width of port ids; must satisfy 2^ID_W >= NUM_PORTS.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  bus clock.
- rst_n  input  1  asynchronous active-low reset.
- src_valid  input  NUM_PORTS  per-source request.
- src_ready  output  NUM_PORTS  per-source grant; transfer happens on src_valid[i] & src_ready[i].
- src_data  input  NUM_PORTS*DATA_WIDTH  per-source word; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- src_dst  input  NUM_PORTS*ID_W  per-source destination id.
- dst_valid  output  NUM_PORTS  per-destination word available.
- dst_data  output  NUM_PORTS*DATA_WIDTH  per-destination held word.
- dst_src  output  NUM_PORTS*ID_W  id of the source that sent the held word.
- dst_ready  input  NUM_PORTS  per-destination accept.
- drop_cnt  output  CNT_W  count of words dropped for an out-of-range destination.

Behaviour:
- Reset (async, rst_n=0):
  - dst_valid=0, dst_data=0, dst_src=0, drop_cnt=0.
  - Round-robin pointer last_grant=NUM_PORTS-1, so port 0 has first priority.
  - src_ready is combinational and is 0 while in reset.
- Eligibility: source i is eligible when src_valid[i]=1 and one of the following holds:
  - d=src_dst[i] is >= NUM_PORTS (out of range), or
  - dst_valid[d]=0, or
  - dst_ready[d]=1 (slot drains this cycle).
- Arbitration:
  - Combinational, one grant per cycle.
  - Pick the first eligible source scanning last_grant+1, last_grant+2, ... modulo NUM_PORTS.
  - src_ready is one-hot or zero; src_ready[i] never asserts without eligible src_valid[i].
- Transfer on grant g to in-range destination d:
  - Next edge: dst_valid[d]=1, dst_data[d]=src_data[g], dst_src[d]=g, last_grant=g.
  - Latency from source handshake to dst_valid: 1 cycle.
- Out-of-range grant:
  - The word is consumed (src_ready pulses) and discarded.
  - drop_cnt increments, saturating at all-ones.
  - last_grant=g.
- Drain: on dst_valid[d] & dst_ready[d] with no new write to d, dst_valid[d] clears next edge. If a write to d occurs in the same cycle, dst_valid[d] stays 1 and data is replaced by the new word (back-to-back, no bubble).
- Hold rule: dst_data/dst_src stay stable while dst_valid=1 and dst_ready=0.
- Source rule: src_data/src_dst must stay stable while src_valid=1 and src_ready=0. The hub does not check this.
- Loopback (src_dst[i]=i) is legal and behaves as any other transfer.
- Contention: multiple sources targeting the same or different destinations are serialised, one per cycle, in round-robin order. A blocked destination does not block sources targeting other destinations; they may be granted in the same cycle the blocked source waits.
- dst_ready while dst_valid=0 is ignored.
- Reset mid-transfer: held words are lost and the pointer returns to NUM_PORTS-1. No partial state survives.
- Throughput: sustained 1 word/cycle when destinations are ready.

Test Plan:
All scenarios use NUM_PORTS=4, DATA_WIDTH=8, ID_W=2.

1. Single transfer.
   - Stimulus: after reset, src0 valid, data 0xA5, dst 2; dst_ready all 1.
   - Response: src_ready=0001 that cycle; next cycle dst_valid=0100, dst_data[2]=0xA5, dst_src[2]=0.
2. Round-robin fairness.
   - Stimulus: src0..3 all valid to dst 1 continuously, dst_ready[1]=1.
   - Response: grants in order 0,1,2,3,0,…; one word/cycle; dst_src[1] sequence 0,1,2,3.
3. Backpressure.
   - Stimulus: dst_ready[3]=0; src1 sends 0x11 to 3, then src2 sends 0x22 to 3.
   - Response: 0x11 held with dst_valid[3]=1; src_ready[2] stays 0. When dst_ready[3] rises, 0x22 appears the next cycle with no bubble.
4. Non-blocking.
   - Stimulus: dst 3 full and not ready; src0→dst3 and src1→dst0 valid simultaneously.
   - Response: src1 granted; src0 waits; dst_data[0] equals src1's word after 1 cycle.
5. Drop counter.
   - Configuration: NUM_PORTS=3, ID_W=2.
   - Stimulus: src0 sends to id 3, 300 times.
   - Response: each is consumed; no dst_valid; drop_cnt saturates at 0xFF.
6. Async reset.
   - Stimulus: assert rst_n low mid-stream between clock edges.
   - Response: dst_valid=0 and drop_cnt=0 immediately; after release, the first grant among all-valid sources is port 0.
